// File: rtl/egress_frame_serializer_if.sv
// Fabric-side and MAC-side signals of the egress frame serializer.
// Optional statistics outputs appear when EGRESS_STATS_EN is defined.
interface egress_frame_serializer_if;
   logic         frame_valid;
   logic         frame_last;
   logic [4:0]   frame_bytes;
   logic [127:0] frame_data;
   logic         space_avail;
   logic         tx_ready;
   logic         tx_start;
   logic         tx_data_valid;
   logic [2:0]   tx_bytes_valid;
   logic [31:0]  tx_data;
   logic [15:0]  drop_count;
`ifdef EGRESS_STATS_EN
   logic [31:0]  tx_frame_count;
   logic [47:0]  tx_byte_count;

   modport master (
      output frame_valid, frame_last, frame_bytes, frame_data, tx_ready,
      input  space_avail, tx_start, tx_data_valid, tx_bytes_valid, tx_data, drop_count,
      input  tx_frame_count, tx_byte_count
   );
   modport slave (
      input  frame_valid, frame_last, frame_bytes, frame_data, tx_ready,
      output space_avail, tx_start, tx_data_valid, tx_bytes_valid, tx_data, drop_count,
      output tx_frame_count, tx_byte_count
   );
`else
   modport master (
      output frame_valid, frame_last, frame_bytes, frame_data, tx_ready,
      input  space_avail, tx_start, tx_data_valid, tx_bytes_valid, tx_data, drop_count
   );
   modport slave (
      input  frame_valid, frame_last, frame_bytes, frame_data, tx_ready,
      output space_avail, tx_start, tx_data_valid, tx_bytes_valid, tx_data, drop_count
   );
`endif
endinterface

// File: rtl/egress_frame_serializer.sv
// Store-and-forward egress serializer: 128-bit fabric words in, 32-bit MAC lanes out.
// Define EGRESS_STATS_EN to add tx_frame_count / tx_byte_count statistics outputs.
// Handshake: fabric words are accepted unconditionally when frame_valid=1 (space_avail is
// advisory); tx_ready only gates the start of a new frame, never lanes inside one.
module egress_frame_serializer #(
   parameter int DEPTH           = 256,
   parameter int MAX_FRAME_WORDS = 96,
   parameter int DESC_DEPTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   egress_frame_serializer_if.slave  bus,
   output logic [1:0]                o_dbg_state
);
   localparam int AW  = $clog2(DEPTH);
   localparam int DAW = $clog2(DESC_DEPTH);
   localparam logic [AW:0]  C_DEPTH = DEPTH[AW:0];
   localparam logic [AW:0]  C_MAX   = MAX_FRAME_WORDS[AW:0];
   localparam logic [AW:0]  C_ONE   = 1;
   localparam logic [AW-1:0] C_ONE_A = 1;
   localparam logic [DAW:0] C_DONE  = 1;

   typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

   logic [127:0]  r_mem [DEPTH];
   logic [AW+5:0] r_desc_mem [DESC_DEPTH];
   logic [127:0]  r_rd_data;

   logic [AW:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr, r_used, r_word;
   logic [AW-1:0] r_rd_addr;
   logic [DAW:0]  r_dwr_ptr, r_drd_ptr;
   logic [1:0]    r_lane;
   logic [15:0]   r_drop_count;
   logic          r_dropping, r_space;
   state_t        r_state, w_state_nxt;

   logic          w_data_full, w_desc_full, w_desc_empty, w_desc_full_nxt;
   logic          w_drop, w_wr_en, w_push, w_pop, w_rd_en, w_final, w_last_word;
   logic [AW:0]   w_frame_len, w_pending, w_used_nxt, w_free_nxt, w_cur_len, w_len_m1;
   logic [AW-1:0] w_rd_addr;
   logic [DAW:0]  w_dwr_nxt, w_drd_nxt;
   logic [AW+5:0] w_head;
   logic [4:0]    w_cur_bytes;
   logic [3:0]    w_bm1;
   logic          w_tx_start, w_tx_dv;
   logic [2:0]    w_tx_bv;
   logic [31:0]   w_tx_data;

   // ---------------- write side ----------------
   assign w_data_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_desc_full  = (r_dwr_ptr[DAW] != r_drd_ptr[DAW]) &&
                         (r_dwr_ptr[DAW-1:0] == r_drd_ptr[DAW-1:0]);
   assign w_desc_empty = (r_dwr_ptr == r_drd_ptr);
   assign w_drop       = bus.frame_valid && !r_dropping &&
                         (w_data_full || (bus.frame_last && w_desc_full));
   assign w_wr_en      = bus.frame_valid && !r_dropping && !w_drop;
   assign w_push       = w_wr_en && bus.frame_last;
   assign w_pending    = r_wr_ptr - r_commit_ptr;
   assign w_frame_len  = w_pending + C_ONE;

   // Occupancy is tracked against the read (free) pointer, so it includes uncommitted words.
   assign w_used_nxt = r_used + {{AW{1'b0}}, w_wr_en}
                       - (w_pop  ? w_cur_len : '0)
                       - (w_drop ? w_pending : '0);
   assign w_free_nxt = C_DEPTH - w_used_nxt;
   assign w_dwr_nxt  = r_dwr_ptr + (w_push ? C_DONE : '0);
   assign w_drd_nxt  = r_drd_ptr + (w_pop  ? C_DONE : '0);
   assign w_desc_full_nxt = (w_dwr_nxt[DAW] != w_drd_nxt[DAW]) &&
                            (w_dwr_nxt[DAW-1:0] == w_drd_nxt[DAW-1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_dwr_ptr    <= '0;
         r_dropping   <= 1'b0;
         r_drop_count <= '0;
         r_used       <= '0;
         r_space      <= 1'b0;
      end else begin
         r_used    <= w_used_nxt;
         r_space   <= (w_free_nxt >= C_MAX) && !w_desc_full_nxt;
         r_dwr_ptr <= w_dwr_nxt;
         if (bus.frame_valid && r_dropping && bus.frame_last)
            r_dropping <= 1'b0;
         if (w_drop) begin
            r_wr_ptr   <= r_commit_ptr;
            r_dropping <= !bus.frame_last;
            if (r_drop_count != 16'hFFFF)
               r_drop_count <= r_drop_count + 16'd1;
         end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + C_ONE;
            if (bus.frame_last)
               r_commit_ptr <= r_wr_ptr + C_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_wr_ptr[AW-1:0]] <= bus.frame_data;
      if (w_push)
         r_desc_mem[r_dwr_ptr[DAW-1:0]] <= {w_frame_len, bus.frame_bytes};
      if (w_rd_en)
         r_rd_data <= r_mem[w_rd_addr];
   end

   // ---------------- read side ----------------
   assign w_head      = r_desc_mem[r_drd_ptr[DAW-1:0]];
   assign w_cur_len   = w_head[AW+5:5];
   assign w_cur_bytes = w_head[4:0];
   assign w_len_m1    = w_cur_len - C_ONE;
   assign w_bm1       = 4'(w_cur_bytes - 5'd1);
   assign w_last_word = (r_word == w_len_m1);
   assign w_final     = (r_state == DATA) && w_last_word && (r_lane == w_bm1[3:2]);
   assign w_pop       = w_final;
   // The next word is fetched on lane 3 so its data lands exactly when lane 0 is due.
   assign w_rd_en     = (r_state == START) || ((r_state == DATA) && (r_lane == 2'd3) && !w_last_word);
   assign w_rd_addr   = (r_state == START) ? r_rd_ptr[AW-1:0] : r_rd_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_start  = 1'b0;
      w_tx_dv     = 1'b0;
      w_tx_bv     = 3'd0;
      w_tx_data   = 32'd0;
      case (r_state)
         IDLE:  if (!w_desc_empty && bus.tx_ready) w_state_nxt = START;
         START: begin
            w_tx_start  = 1'b1;
            w_state_nxt = DATA;
         end
         DATA: begin
            w_tx_dv = 1'b1;
            w_tx_bv = w_final ? ({1'b0, w_bm1[1:0]} + 3'd1) : 3'd4;
            case (r_lane)
               2'd0:    w_tx_data = r_rd_data[127:96];
               2'd1:    w_tx_data = r_rd_data[95:64];
               2'd2:    w_tx_data = r_rd_data[63:32];
               default: w_tx_data = r_rd_data[31:0];
            endcase
            if (w_final) w_state_nxt = GAP;
         end
         GAP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr  <= '0;
         r_rd_addr <= '0;
         r_drd_ptr <= '0;
         r_word    <= '0;
         r_lane    <= '0;
      end else if (r_state == START) begin
         r_rd_addr <= r_rd_ptr[AW-1:0] + C_ONE_A;
         r_word    <= '0;
         r_lane    <= '0;
      end else if (r_state == DATA) begin
         if (w_final) begin
            r_rd_ptr  <= r_rd_ptr + w_cur_len;
            r_drd_ptr <= w_drd_nxt;
         end else begin
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
               r_word    <= r_word + C_ONE;
               r_rd_addr <= r_rd_addr + C_ONE_A;
            end
         end
      end
   end

`ifdef EGRESS_STATS_EN
   logic [31:0] r_tx_frame_count;
   logic [47:0] r_tx_byte_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_frame_count <= '0;
         r_tx_byte_count  <= '0;
      end else if (w_final) begin
         r_tx_frame_count <= r_tx_frame_count + 32'd1;
         r_tx_byte_count  <= r_tx_byte_count + 48'({w_len_m1, 4'b0000}) + 48'(w_cur_bytes);
      end
   end

   assign bus.tx_frame_count = r_tx_frame_count;
   assign bus.tx_byte_count  = r_tx_byte_count;
`endif

   assign bus.tx_start       = w_tx_start;
   assign bus.tx_data_valid  = w_tx_dv;
   assign bus.tx_bytes_valid = w_tx_bv;
   assign bus.tx_data        = w_tx_data;
   assign bus.space_avail    = r_space;
   assign bus.drop_count     = r_drop_count;
   assign o_dbg_state        = r_state;
endmodule
